// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared constants, channel state type and tick conversion for button_bank
package button_pkg;

    // Depth of the metastability synchroniser in front of every channel.
    localparam int unsigned SYNC_DEPTH = 2;

    // Per-channel debounce state: debounced level plus whether a change is being timed.
    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        ARMING_PRESS   = 2'd1,
        HELD           = 2'd2,
        ARMING_RELEASE = 2'd3
    } channel_state_t;

    // Converts a duration in milliseconds into clock ticks.
    function automatic int unsigned ms_to_ticks(input int unsigned freq, input int unsigned ms);
        return (freq / 1000) * ms;
    endfunction

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one debounced button: synchroniser, debounce FSM, hold and repeat timers
module button_channel
    import button_pkg::*;
#(
    parameter logic        ACTIVE         = 1'b1,
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned LONG_TICKS     = 20
`ifdef BUTTON_REPEAT_EN
    ,
    parameter int unsigned REPEAT_TICKS   = 5
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int DW = $clog2(DEBOUNCE_TICKS);
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [DW-1:0] DCNT_ONE  = DW'(1);
    localparam logic [HW-1:0] HCNT_LONG = HW'(LONG_TICKS - 1);
    localparam logic [HW-1:0] HCNT_SAT  = HW'(LONG_TICKS);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  lvl;
    channel_state_t        fsm_q;
    channel_state_t        fsm_d;
    logic [DW-1:0]         dcnt_q;
    logic [DW-1:0]         dcnt_d;
    logic                  level_q;
    logic                  press_d;
    logic                  release_d;
    logic [HW-1:0]         hcnt_q;
    logic                  long_d;
    logic                  press_q;
    logic                  release_q;
    logic                  long_q;

    // Synchroniser; reset loads the inactive raw level so a channel never starts out pressed.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_DEPTH{~ACTIVE}};
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], pin};
        end
    end

    assign lvl = sync_q[SYNC_DEPTH-1] ~^ ACTIVE;

    // Debounce state and window counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q  <= IDLE;
            dcnt_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            dcnt_q <= dcnt_d;
        end
    end

    // Debounce next state: a change is accepted only after a full window of stable input.
    always_comb begin
        fsm_d     = fsm_q;
        dcnt_d    = dcnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                if (lvl) begin
                    fsm_d  = ARMING_PRESS;
                    dcnt_d = DCNT_ONE;
                end
            end
            ARMING_PRESS: begin
                if (!lvl) begin
                    fsm_d  = IDLE;
                    dcnt_d = '0;
                end else if (dcnt_q == DCNT_LAST) begin
                    fsm_d   = HELD;
                    dcnt_d  = '0;
                    press_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!lvl) begin
                    fsm_d  = ARMING_RELEASE;
                    dcnt_d = DCNT_ONE;
                end
            end
            ARMING_RELEASE: begin
                if (lvl) begin
                    fsm_d  = HELD;
                    dcnt_d = '0;
                end else if (dcnt_q == DCNT_LAST) begin
                    fsm_d     = IDLE;
                    dcnt_d    = '0;
                    release_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: begin
                fsm_d  = IDLE;
                dcnt_d = '0;
            end
        endcase
    end

    // Debounced level kept in its own flop so the output is glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
        end else if (press_d) begin
            level_q <= 1'b1;
        end else if (release_d) begin
            level_q <= 1'b0;
        end
    end

    // Hold timer: runs while pressed and saturates one past the long-press point.
    always_ff @(posedge clk) begin
        if (reset || !level_q) begin
            hcnt_q <= '0;
        end else if (hcnt_q != HCNT_SAT) begin
            hcnt_q <= hcnt_q + 1'b1;
        end
    end

    // A release on the expiry edge wins over the long press.
    assign long_d = level_q && (hcnt_q == HCNT_LONG) && !release_d;

    // Registered one-cycle strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;

`ifdef BUTTON_REPEAT_EN
    localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [RW-1:0] RCNT_LAST = RW'(REPEAT_TICKS - 1);

    logic [RW-1:0] rcnt_q;
    logic          repeat_d;
    logic          repeat_q;

    // Repeats run only once the hold timer has saturated, i.e. after LONG has fired.
    assign repeat_d = level_q && (hcnt_q == HCNT_SAT) && (rcnt_q == RCNT_LAST) && !release_d;

    // Repeat period counter, phase-aligned to the LONG strobe.
    always_ff @(posedge clk) begin
        if (reset || !level_q || long_d || release_d) begin
            rcnt_q <= '0;
        end else if (hcnt_q == HCNT_SAT) begin
            rcnt_q <= (rcnt_q == RCNT_LAST) ? '0 : rcnt_q + 1'b1;
        end
    end

    // Registered repeat strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= repeat_d;
        end
    end

    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_bank.sv
// rtl/button_bank.sv - multi-channel button debouncer top; auto-repeat enabled by BUTTON_REPEAT_EN
module button_bank
    import button_pkg::*;
#(
    parameter int unsigned          CHANNELS    = 4,
    parameter logic [CHANNELS-1:0]  ACTIVE_MASK = {CHANNELS{1'b1}},
    parameter int unsigned          CLK_FREQ    = 100000000,
    parameter int unsigned          DEBOUNCE_MS = 10,
    parameter int unsigned          LONG_MS     = 1000,
    parameter int unsigned          REPEAT_MS   = 100
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [CHANNELS-1:0] PIN,
    output logic [CHANNELS-1:0] STATE,
    output logic [CHANNELS-1:0] PRESS,
    output logic [CHANNELS-1:0] RELEASE,
    output logic [CHANNELS-1:0] LONG,
    output logic [CHANNELS-1:0] REPEAT
);

    localparam int unsigned DEBOUNCE_TICKS = ms_to_ticks(CLK_FREQ, DEBOUNCE_MS);
    localparam int unsigned LONG_TICKS     = ms_to_ticks(CLK_FREQ, LONG_MS);
`ifdef BUTTON_REPEAT_EN
    localparam int unsigned REPEAT_TICKS   = ms_to_ticks(CLK_FREQ, REPEAT_MS);
`endif

    // Channels are fully independent; each gets its own polarity bit.
    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
        button_channel #(
            .ACTIVE         (ACTIVE_MASK[i]),
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .LONG_TICKS     (LONG_TICKS)
`ifdef BUTTON_REPEAT_EN
            ,
            .REPEAT_TICKS   (REPEAT_TICKS)
`endif
        ) u_channel (
            .clk           (CLK),
            .reset         (RESET),
            .pin           (PIN[i]),
            .level         (STATE[i]),
            .press_pulse   (PRESS[i]),
            .release_pulse (RELEASE[i]),
            .long_pulse    (LONG[i]),
            .repeat_pulse  (REPEAT[i])
        );
    end

endmodule

// File: tb/tb_button_bank.sv
// tb/tb_button_bank.sv - randomized scoreboard bench for button_bank against a window-based reference model
module tb_button_bank;

    localparam int         CH   = 2;
    localparam logic [1:0] MASK = 2'b01;
    localparam int         D    = 4;
    localparam int         L    = 20;
    localparam int         R    = 5;
    localparam int         MAXC = 8192;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [1:0] PIN = 2'b10;
    logic [1:0] STATE, PRESS, RELEASE, LONG, REPEAT;

    button_bank #(
        .CHANNELS    (CH),
        .ACTIVE_MASK (MASK),
        .CLK_FREQ    (1000),
        .DEBOUNCE_MS (4),
        .LONG_MS     (20),
        .REPEAT_MS   (5)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .PIN     (PIN),
        .STATE   (STATE),
        .PRESS   (PRESS),
        .RELEASE (RELEASE),
        .LONG    (LONG),
        .REPEAT  (REPEAT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        int         cyc;
        logic [1:0] state;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] lng;
        logic [1:0] rpt;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         rst_h [MAXC];
    logic [1:0] pin_h [MAXC];
    bit         m_s     [CH];
    int         m_last  [CH];
    int         m_press [CH];

    // Normalised level the debouncer sees at edge j: the pin captured two edges earlier,
    // forced inactive if either synchroniser stage was being reset.
    function automatic bit lvl_at(input int j, input int ch);
        if (j < 3) return 1'b0;
        if (rst_h[j-1] || rst_h[j-2]) return 1'b0;
        return pin_h[j-2][ch] == MASK[ch];
    endfunction

    // Reference: a toggle needs D consecutive edges disagreeing with the level, none of them
    // overlapping a previous toggle or reset; LONG/REPEAT are timed from the press edge.
    task automatic model_edge(input int e);
        exp_t x;
        x = '0;
        x.cyc = e;
        for (int ch = 0; ch < CH; ch++) begin
            bit pre;
            bit tog;
            int held;
            if (rst_h[e]) begin
                m_s[ch]    = 1'b0;
                m_last[ch] = e;
            end else begin
                pre = m_s[ch];
                tog = (e - D >= m_last[ch]);
                for (int j = e - D + 1; j <= e; j++)
                    if (lvl_at(j, ch) == pre) tog = 1'b0;
                held = e - m_press[ch];
                if (tog) begin
                    m_s[ch]    = ~pre;
                    m_last[ch] = e;
                    if (!pre) begin
                        x.press[ch] = 1'b1;
                        m_press[ch] = e;
                    end else begin
                        x.rel[ch] = 1'b1;
                    end
                end else if (pre) begin
                    if (held == L) x.lng[ch] = 1'b1;
`ifdef BUTTON_REPEAT_EN
                    if (held > L && ((held - L) % R) == 0) x.rpt[ch] = 1'b1;
`endif
                end
            end
            x.state[ch] = m_s[ch];
        end
        exp_q.push_back(x);
    endtask

    // One clock: drive at the falling edge, log what the rising edge captured, predict outputs.
    task automatic step(input logic [1:0] act, input bit r);
        logic [1:0] raw;
        raw = ~(act ^ MASK);
        @(negedge CLK);
        PIN   = raw;
        RESET = r;
        @(posedge CLK);
        cyc++;
        pin_h[cyc] = raw;
        rst_h[cyc] = r;
        model_edge(cyc);
    endtask

    task automatic run(input logic [1:0] act, input int n, input bit r);
        for (int i = 0; i < n; i++) step(act, r);
    endtask

    task automatic chk(input string name, input int c, input logic [1:0] got, input logic [1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s edge %0d got %b expected %b", name, c, got, want);
        end
    endtask

    // Monitor: every registered output set is compared against the prediction for its edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("state",   x.cyc, STATE,   x.state);
                chk("press",   x.cyc, PRESS,   x.press);
                chk("release", x.cyc, RELEASE, x.rel);
                chk("long",    x.cyc, LONG,    x.lng);
                chk("repeat",  x.cyc, REPEAT,  x.rpt);
            end
        end
    end

    initial begin
        logic [1:0] act;
        int         remain [CH];
        for (int ch = 0; ch < CH; ch++) begin
            m_s[ch]     = 1'b0;
            m_last[ch]  = 0;
            m_press[ch] = 0;
            remain[ch]  = 0;
        end

        run(2'b00, 3, 1'b1);
        run(2'b00, 10, 1'b0);
        // clean press and release on ch0
        run(2'b01, 12, 1'b0);
        run(2'b00, 12, 1'b0);
        // glitch train shorter than the window, then a real press held into LONG/REPEAT
        for (int k = 0; k < 5; k++) begin
            run(2'b01, 3, 1'b0);
            run(2'b00, 1, 1'b0);
        end
        run(2'b01, 50, 1'b0);
        run(2'b00, 12, 1'b0);
        // active-low ch1 together with ch0
        run(2'b11, 10, 1'b0);
        run(2'b00, 12, 1'b0);
        // release debounced exactly on the LONG expiry edge
        run(2'b01, 20, 1'b0);
        run(2'b00, 12, 1'b0);
        // reset while held, button kept down through and after reset
        run(2'b01, 15, 1'b0);
        run(2'b01, 2, 1'b1);
        run(2'b01, 12, 1'b0);
        run(2'b00, 10, 1'b0);

        // random segments: bursty glitches, medium and long holds, rare resets
        act = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            for (int ch = 0; ch < CH; ch++) begin
                if (remain[ch] == 0) begin
                    act[ch] = ~act[ch];
                    case ($urandom_range(0, 3))
                        0:       remain[ch] = $urandom_range(1, 4);
                        1:       remain[ch] = $urandom_range(3, 8);
                        2:       remain[ch] = $urandom_range(8, 30);
                        default: remain[ch] = $urandom_range(30, 60);
                    endcase
                end
                remain[ch]--;
            end
            step(act, ($urandom_range(0, 399) == 0));
        end

        run(2'b00, 12, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
